prog_loader: RTL

Sequential program loader sitting directly upstream of the SAP CPU's program memory. It accepts a framed byte stream over a valid/ready handshake and writes it into the 16×8 memory starting at address 0. While loading, it holds the CPU halted. After a good checksum it pulses a CPU reset so execution restarts from PC = 0. On a bad frame it keeps the CPU halted and flags an error.

---
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Receives a framed byte stream (LEN, N data bytes, CSUM) over a valid/ready
// handshake and writes the data bytes into the CPU program memory starting at
// address 0. The CPU is held frozen for the whole session. A good checksum
// ends with a one-cycle CPU reset pulse and releases the CPU. A bad length,
// a bad checksum or an abort leaves the CPU frozen and raises err.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      one-cycle request to begin a session (IDLE/DONE/ERROR only)
//   abort      cancels an active session (LEN/DATA/CSUM only)
//   rx_valid   rx_data holds a byte
//   rx_data    incoming stream byte
//   rx_ready   loader accepts a byte this cycle
//   ram_we     memory write strobe, one cycle per data byte
//   ram_addr   memory write address
//   ram_wdata  memory write data
//   cpu_hold   CPU halt request, 1 = frozen
//   cpu_rst    one-cycle CPU reset pulse on successful release
//   busy       a session is active
//   done       sticky: last session succeeded
//   err        sticky: last session failed
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit so that a length of DEPTH and the final index both fit
    // without wrapping.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                rx_ready_q, busy_q, cpu_hold_q, cpu_rst_q, done_q, err_q;

    logic                accept;
    logic [DATA_W-1:0]   csum_total;

    assign accept     = rx_valid && rx_ready_q;
    assign csum_total = sum_q + rx_data;

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            S_LEN: begin
                // abort wins over a byte offered in the same cycle
                if (abort) begin
                    state_d = S_ERROR;
                end else if (accept) begin
                    if (rx_data == '0 || int'(rx_data) > DEPTH) begin
                        state_d = S_ERROR;
                    end else begin
                        len_d   = CNT_W'(rx_data);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[ADDR_W-1:0];
                    ram_wdata_d = rx_data;
                    sum_d       = sum_q + rx_data;
                    idx_d       = idx_q + CNT_W'(1);
                    if (idx_q + CNT_W'(1) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else if (accept) begin
                    state_d = (csum_total == '0) ? S_RELEASE : S_ERROR;
                end
            end
            S_RELEASE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // All outputs are registered and decoded from the next state, so they
    // change on the same edge as the state they describe. done/err stay set
    // for as long as the FSM rests in DONE/ERROR, which makes them sticky
    // until the next accepted start.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_hold_q  <= 1'b0;
            cpu_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rx_ready_q  <= state_d inside {S_LEN, S_DATA, S_CSUM};
            busy_q      <= state_d inside {S_LEN, S_DATA, S_CSUM, S_RELEASE};
            cpu_hold_q  <= state_d inside {S_LEN, S_DATA, S_CSUM, S_RELEASE, S_ERROR};
            cpu_rst_q   <= (state_d == S_RELEASE);
            done_q      <= (state_d == S_DONE);
            err_q       <= (state_d == S_ERROR);
        end
    end

    assign rx_ready  = rx_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
